// File: rtl/tt_resistor_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tt_resistor_scan_ctrl
//  Description : Resistor test array sequencer. Walks a masked set of analog
//                channels, enables one structure at a time onto the shared
//                measurement bus with break-before-make dead time and a
//                settle interval, and runs a req/ack handshake per channel.
//  Revision    : 1.0  initial release
// ============================================================================
module tt_resistor_scan_ctrl #(
    parameter int N_CH           = 8,
    parameter int DEAD_CYCLES    = 2,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  ena,
    input  logic                                  start,
    input  logic [N_CH-1:0]                       ch_mask,
    input  logic                                  meas_ack,
    output logic [N_CH-1:0]                       mux_en,
    output logic                                  meas_req,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cur_idx,
    output logic                                  busy,
    output logic                                  done,
    output logic [N_CH-1:0]                       err_mask
);

    localparam int IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int MAX_DS  = (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
    localparam int MAX_CNT = (TIMEOUT_CYCLES > MAX_DS) ? TIMEOUT_CYCLES : MAX_DS;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    // Terminal counts: the counter starts at 0 on the first cycle of a phase
    localparam logic [CNT_W-1:0] DEAD_LAST   = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [N_CH-1:0]  ONE_HOT0    = {{(N_CH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DEAD    = 3'd1,
        S_SETTLE  = 3'd2,
        S_REQ     = 3'd3,
        S_RELEASE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0]   pend_q, pend_d;
    logic [N_CH-1:0]   err_q, err_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              load_idx;
    logic [IDX_W-1:0]  w_lowest_idx;
    logic              ack_meta_q, ack_s_q;
    logic [N_CH-1:0]   mux_q, mux_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Two-flop synchronizer for the asynchronous tester acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= meas_ack;
            ack_s_q    <= ack_meta_q;
        end
    end

    // State, counters, channel bookkeeping and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            err_q   <= '0;
            idx_q   <= '0;
            mux_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            mux_q   <= mux_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; every channel exit shares one "next channel or done" path
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        pend_d   = pend_q;
        err_d    = err_q;
        load_idx = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start && ena) begin
                    pend_d = ch_mask;
                    err_d  = '0;
                    if (ch_mask != '0) begin
                        state_d  = S_DEAD;
                        load_idx = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DEAD: begin
                if (cnt_q == DEAD_LAST) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_REQ;
                    cnt_d   = '0;
                end
            end
            S_REQ: begin
                if (ack_s_q) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    err_d[idx_q]  = 1'b1;
                    pend_d[idx_q] = 1'b0;
                    cnt_d         = '0;
                    if (pend_d != '0) begin
                        state_d  = S_DEAD;
                        load_idx = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RELEASE: begin
                if (!ack_s_q || (cnt_q == TMO_LAST)) begin
                    if (ack_s_q) begin
                        err_d[idx_q] = 1'b1;
                    end
                    pend_d[idx_q] = 1'b0;
                    cnt_d         = '0;
                    if (pend_d != '0) begin
                        state_d  = S_DEAD;
                        load_idx = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Tile disable aborts from any state; error history is kept
        if (!ena) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            pend_d   = pend_q;
            err_d    = err_q;
            load_idx = 1'b0;
        end
    end

    // Lowest pending channel, giving ascending visit order with free skips
    always_comb begin
        w_lowest_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pend_d[i]) begin
                w_lowest_idx = IDX_W'(i);
            end
        end
    end

    // Output decode from the next state so every output is a flop
    always_comb begin
        idx_d  = load_idx ? w_lowest_idx : idx_q;
        mux_d  = '0;
        if ((state_d == S_SETTLE) || (state_d == S_REQ) || (state_d == S_RELEASE)) begin
            mux_d = ONE_HOT0 << idx_d;
        end
        req_d  = (state_d == S_REQ);
        busy_d = (state_d == S_DEAD) || (state_d == S_SETTLE) ||
                 (state_d == S_REQ)  || (state_d == S_RELEASE);
        done_d = (state_d == S_DONE);
    end

    assign mux_en   = mux_q;
    assign meas_req = req_q;
    assign cur_idx  = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err_mask = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tt_resistor_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tt_resistor_scan_ctrl
//  Description : Self-checking bench for tt_resistor_scan_ctrl. Expected
//                per-cycle outputs are built as a timeline from phase lengths
//                (dead, settle, handshake, done) and replayed against the DUT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tt_resistor_scan_ctrl;

    localparam int DEAD   = 2;
    localparam int SETTLE = 16;
    localparam int TMO    = 1024;
    localparam int ACK_DLY  = 5;   // tester raises ack this many cycles after meas_req rises
    localparam int ACK_HOLD = 3;   // tester drops ack this many cycles after meas_req falls

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic [7:0] ch_mask;
    logic       meas_ack;
    logic [7:0] mux_en;
    logic       meas_req;
    logic [2:0] cur_idx;
    logic       busy;
    logic       done;
    logic [7:0] err_mask;

    tt_resistor_scan_ctrl #(
        .N_CH           (8),
        .DEAD_CYCLES    (DEAD),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .start    (start),
        .ch_mask  (ch_mask),
        .meas_ack (meas_ack),
        .mux_en   (mux_en),
        .meas_req (meas_req),
        .cur_idx  (cur_idx),
        .busy     (busy),
        .done     (done),
        .err_mask (err_mask)
    );

    always #5 clk = ~clk;

    // One timeline entry: inputs to drive this cycle and outputs expected this cycle
    typedef struct packed {
        logic       start;
        logic       ena;
        logic       ack;
        logic [7:0] mux;
        logic       req;
        logic       busy;
        logic       done;
        logic [2:0] idx;
        logic [7:0] err;
    } ent_t;

    ent_t tr[$];
    logic [2:0] m_idx;
    logic [7:0] m_err;

    int n_vec = 0;
    int n_err = 0;

    // Observed-behaviour statistics of the last replayed timeline
    int         st_first_mux, st_first_done, st_done_cnt, st_min_gap, st_zero_run, st_last_ch;
    logic [7:0] st_first_mux_val, st_visited, st_last_nz;
    logic       st_busy_seen, st_asc;
    int         st_req_cyc[8];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic add(input logic s, input logic e, input logic a, input logic [7:0] mx,
                       input logic rq, input logic by, input logic dn);
        ent_t t;
        t.start = s; t.ena = e; t.ack = a; t.mux = mx;
        t.req = rq; t.busy = by; t.done = dn; t.idx = m_idx; t.err = m_err;
        tr.push_back(t);
    endtask

    task automatic add_idle(input int n);
        for (int k = 0; k < n; k++) add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // Expected timeline of a complete scan; channels in noack never see an ack
    task automatic build_scan(input logic [7:0] mask, input logic [7:0] noack);
        ch_mask = mask;
        add(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        m_err = 8'h00;
        for (int c = 0; c < 8; c++) begin
            if (mask[c]) begin
                m_idx = 3'(c);
                for (int k = 0; k < DEAD; k++)   add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
                for (int k = 0; k < SETTLE; k++) add(1'b0, 1'b1, 1'b0, 8'h01 << c, 1'b0, 1'b1, 1'b0);
                if (noack[c]) begin
                    for (int k = 0; k < TMO; k++) add(1'b0, 1'b1, 1'b0, 8'h01 << c, 1'b1, 1'b1, 1'b0);
                    m_err[c] = 1'b1;
                end else begin
                    // ack seen by the FSM 2 cycles after the pad moves, acted on 1 later
                    for (int k = 0; k < ACK_DLY + 3; k++)
                        add(1'b0, 1'b1, k >= ACK_DLY, 8'h01 << c, 1'b1, 1'b1, 1'b0);
                    for (int k = 0; k < ACK_HOLD + 3; k++)
                        add(1'b0, 1'b1, k < ACK_HOLD, 8'h01 << c, 1'b0, 1'b1, 1'b0);
                end
            end
        end
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        add_idle(3);
    endtask

    // Replay the timeline: compare outputs mid-cycle, then drive the next inputs
    task automatic run();
        logic [21:0] got, exp;
        int ch;
        st_first_mux = -1; st_first_done = -1; st_done_cnt = 0; st_min_gap = 9999;
        st_zero_run = 0; st_last_ch = -1; st_first_mux_val = 8'h00; st_visited = 8'h00;
        st_last_nz = 8'h00; st_busy_seen = 1'b0; st_asc = 1'b1;
        for (int k = 0; k < 8; k++) st_req_cyc[k] = 0;
        for (int i = 0; i < tr.size(); i++) begin
            @(negedge clk);
            got = {mux_en, meas_req, busy, done, cur_idx, err_mask};
            exp = {tr[i].mux, tr[i].req, tr[i].busy, tr[i].done, tr[i].idx, tr[i].err};
            chk($sformatf("cycle%0d{mux,req,busy,done,idx,err}", i), 32'(got), 32'(exp));
            if (mux_en != 8'h00) begin
                if (st_first_mux < 0) begin
                    st_first_mux     = i;
                    st_first_mux_val = mux_en;
                end
                st_visited = st_visited | mux_en;
                ch = 0;
                for (int k = 0; k < 8; k++) if (mux_en[k]) ch = k;
                if (mux_en != st_last_nz) begin
                    if (st_last_nz != 8'h00) begin
                        if (st_zero_run < st_min_gap) st_min_gap = st_zero_run;
                        if (ch <= st_last_ch) st_asc = 1'b0;
                    end
                    st_last_ch = ch;
                    st_last_nz = mux_en;
                end
                st_zero_run = 0;
            end else begin
                st_zero_run++;
            end
            if (meas_req) st_req_cyc[cur_idx]++;
            if (done) begin
                st_done_cnt++;
                if (st_first_done < 0) st_first_done = i;
            end
            if (busy) st_busy_seen = 1'b1;
            start    = tr[i].start;
            ena      = tr[i].ena;
            meas_ack = tr[i].ack;
        end
        tr.delete();
    endtask

    initial begin
        ent_t t;
        int   cut;
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; ch_mask = 8'h00; meas_ack = 1'b0;
        m_idx = 3'd0; m_err = 8'h00;

        // Reset state
        #12;
        chk("reset_outputs", {8'h0, mux_en, meas_req, busy, done, cur_idx, err_mask}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        add_idle(2);
        run();

        // Full scan with normal handshakes
        build_scan(8'hFF, 8'h00);
        run();
        chk("full_visited", 32'(st_visited), 32'hFF);
        chk("full_ascending", 32'(st_asc), 32'h1);
        chk("full_min_gap", 32'(st_min_gap), 32'd2);
        chk("full_done_cnt", 32'(st_done_cnt), 32'd1);
        chk("full_err", 32'(err_mask), 32'h00);
        chk("full_busy_after", 32'(busy), 32'h0);

        // Sparse mask: only 0, 2, 7; first enable 3 cycles after start
        build_scan(8'b1000_0101, 8'h00);
        run();
        chk("sparse_visited", 32'(st_visited), 32'h85);
        chk("sparse_first_mux_cycle", 32'(st_first_mux), 32'd3);
        chk("sparse_first_mux_val", 32'(st_first_mux_val), 32'h01);
        chk("sparse_min_gap", 32'(st_min_gap), 32'd2);

        // Empty mask: done straight away, never busy
        build_scan(8'h00, 8'h00);
        run();
        chk("empty_done_cycle", 32'(st_first_done), 32'd1);
        chk("empty_done_cnt", 32'(st_done_cnt), 32'd1);
        chk("empty_busy_seen", 32'(st_busy_seen), 32'h0);
        chk("empty_visited", 32'(st_visited), 32'h00);

        // Timeout on channel 1, normal handshake on channel 2
        build_scan(8'h06, 8'h02);
        run();
        chk("tmo_err", 32'(err_mask), 32'h02);
        chk("tmo_req_cycles_ch1", 32'(st_req_cyc[1]), 32'd1024);
        chk("tmo_req_cycles_ch2", 32'(st_req_cyc[2]), 32'd8);
        chk("tmo_done_cnt", 32'(st_done_cnt), 32'd1);

        // Abort by dropping ena during channel 3 settle, then a fresh scan
        build_scan(8'h18, 8'h00);
        while (tr.size() > 7) void'(tr.pop_back());
        t = tr[6]; t.ena = 1'b0; tr[6] = t;
        m_idx = 3'd3; m_err = 8'h00;
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        add_idle(3);
        run();
        chk("abort_done_cnt", 32'(st_done_cnt), 32'd0);
        build_scan(8'h18, 8'h00);
        run();
        chk("rescan_first_mux_val", 32'(st_first_mux_val), 32'h08);
        chk("rescan_visited", 32'(st_visited), 32'h18);

        // Asynchronous reset while channel 2 is requesting, with err_mask set
        build_scan(8'h06, 8'h02);
        cut = 1 + 2 * (DEAD + SETTLE) + TMO + 3;
        while (tr.size() > cut) void'(tr.pop_back());
        run();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mux", 32'(mux_en), 32'h00);
        chk("arst_req", 32'(meas_req), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_err", 32'(err_mask), 32'h00);
        chk("arst_idx", 32'(cur_idx), 32'h0);
        @(negedge clk);
        meas_ack = 1'b0; start = 1'b0; rst_n = 1'b1;
        m_idx = 3'd0; m_err = 8'h00;
        add_idle(3);
        run();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tt_resistor_scan_ctrl.md
# tt_resistor_scan_ctrl

Sequencer for the resistor test array. It walks a masked set of analog channels and enables one resistor structure at a time onto the shared `ua` measurement bus, with break-before-make dead time and a settle interval. For each channel it runs a request/acknowledge handshake with the off-chip tester. It sits between the dedicated digital pins (`ui_in`/`uo_out`) and the analog mux enables inside the top-level tile.

## Interface
Parameters:
- `N_CH`, 8: number of resistor channels; also the width of `mux_en` and `ch_mask`.
- `DEAD_CYCLES`, 2: cycles during which all mux enables are low before any channel turns on (≥1).
- `SETTLE_CYCLES`, 16: cycles a channel is enabled before `meas_req` rises (≥1).
- `TIMEOUT_CYCLES`, 1024: maximum cycles spent waiting for the synchronized ack, in REQ or in RELEASE.

Ports:
- `clk`  in  1  tile clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ena`  in  1  tile enable; low forces an abort.
- `start`  in  1  level; sampled only in IDLE.
- `ch_mask`  in  N_CH  channels to visit; sampled on the cycle start is accepted.
- `meas_ack`  in  1  tester acknowledge, asynchronous pad input.
- `mux_en`  out  N_CH  one-hot or zero analog switch enables.
- `meas_req`  out  1  "channel settled, measure now".
- `cur_idx`  out  $clog2(N_CH)  index of the current channel.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse at the end of a scan.
- `err_mask`  out  N_CH  sticky per-channel timeout flags.

## Operation
- `meas_ack` passes through a 2-flop synchronizer; all FSM decisions use the synchronized `ack_s`.
- States: IDLE, DEAD, SETTLE, REQ, RELEASE, DONE.
- IDLE: start=1 & ena=1 → latch ch_mask into `pend`, clear err_mask.
  - pend≠0 → DEAD.
  - pend=0 → DONE.
- DEAD: mux_en=0. After DEAD_CYCLES cycles → SETTLE. `cur_idx` is loaded with the lowest set bit of `pend`.
- SETTLE: mux_en = 1<<cur_idx. After SETTLE_CYCLES cycles → REQ.
- REQ: meas_req=1, mux held on.
  - ack_s=1 → RELEASE.
  - Timeout → set err_mask[cur_idx], clear pend[cur_idx], go to DEAD, or to DONE if pend is now empty.
- RELEASE: meas_req=0, mux held on.
  - ack_s=0 → clear pend[cur_idx], then go to DEAD if pend≠0, else DONE.
  - Timeout → set err_mask[cur_idx] and take the same exit.
- DONE: done=1 for exactly one cycle, mux_en=0 → IDLE. Re-entry to a new scan requires start sampled again in IDLE; a held start restarts on the next IDLE cycle.
- mux_en is never more than one-hot. Any change of enabled channel passes through ≥DEAD_CYCLES cycles of mux_en=0.
- ena=0 in any state → next cycle IDLE, mux_en=0, meas_req=0, busy=0. No done pulse. err_mask is retained.
- Channels are visited in ascending index order; masked-off channels are skipped at zero cost.

## Timing
- Reset values: mux_en=0, meas_req=0, busy=0, done=0, cur_idx=0, err_mask=0, state IDLE, synchronizer flops 0.
- All outputs are registered.
- busy=1 from the cycle after start is accepted through the last non-DONE cycle. It is 0 in the DONE cycle.
- Start edge to first mux_en high: 1 + DEAD_CYCLES cycles.
- mux_en high to meas_req high: SETTLE_CYCLES cycles.
- meas_ack pad rise to meas_req fall: 3 cycles (2 synchronizer + 1 state register).
- Timeout counter clears on entry to REQ and again on entry to RELEASE. The timeout fires on the cycle the count reaches TIMEOUT_CYCLES.
- Asynchronous reset mid-scan: all outputs reach reset values immediately, without waiting for a clock.

## Test plan
- Full scan: ch_mask=8'hFF, tester acks 5 cycles after each meas_req rise and drops ack 3 cycles after meas_req falls → mux_en steps 01,02,…,80 with a ≥2-cycle zero gap between steps. Expect done pulse once, err_mask=0, busy=0 afterwards.
- Sparse mask: ch_mask=8'b1000_0101 → channels 0, 2, 7 visited only. First mux_en=01 exactly 3 cycles after start.
- Empty mask: ch_mask=0 with start → done high on the 2nd cycle, mux_en stays 0, busy never asserts.
- Timeout: ch_mask=8'h06, no ack on channel 1, normal ack on channel 2 → err_mask=8'h02 after done. Channel 1 holds meas_req for exactly 1024 cycles.
- Abort: drop ena during SETTLE of channel 3 → next cycle mux_en=0, busy=0, no done pulse. A fresh start rescans from the lowest masked channel.
- Async reset mid-REQ: assert rst_n=0 between clock edges → mux_en, meas_req, busy go to 0 before the next edge. err_mask reads 0.
